// File: rtl/face_result_uart_tx.sv
// Face-detection result UART transmitter: record FIFO, CTS-paced 8N1 packets (found, c0, r0, c1, r1).
// Define FACE_TX_CHECKSUM_EN to append an XOR checksum byte to every packet.
module face_result_uart_tx #(
    parameter int BAUD_DIV   = 54,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rec_valid,
    output logic       rec_ready,
    input  logic [7:0] rec_found,
    input  logic [7:0] rec_r0,
    input  logic [7:0] rec_c0,
    input  logic [7:0] rec_r1,
    input  logic [7:0] rec_c1,
    input  logic       uart_cts,
    output logic       uart_tx,
    output logic       uart_rts,
    output logic       busy
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
`ifdef FACE_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_CTS
    } state_t;

    logic [39:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop;
    logic          link_up;

    logic          cts_meta, cts_s;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    idx_q, idx_d;
    logic [39:0]   pkt_q;
    logic          load;
    logic [7:0]    cur_byte;
    logic          tx_q, tx_d;
    logic          busy_q;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rec_ready = link_up & ~full;
    assign push      = rec_valid & rec_ready;
    assign uart_rts  = link_up;
    assign uart_tx   = tx_q;
    assign busy      = busy_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            link_up  <= 1'b0;
            cts_meta <= 1'b0;
            cts_s    <= 1'b0;
        end else begin
            link_up  <= 1'b1;
            cts_meta <= uart_cts;
            cts_s    <= cts_meta;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {rec_found, rec_c0, rec_r0, rec_c1, rec_r1};
    end

    always_comb begin
        cur_byte = '0;
        case (idx_q)
            3'd0:    cur_byte = pkt_q[39:32];
            3'd1:    cur_byte = pkt_q[31:24];
            3'd2:    cur_byte = pkt_q[23:16];
            3'd3:    cur_byte = pkt_q[15:8];
            3'd4:    cur_byte = pkt_q[7:0];
`ifdef FACE_TX_CHECKSUM_EN
            3'd5:    cur_byte = pkt_q[39:32] ^ pkt_q[31:24] ^ pkt_q[23:16] ^ pkt_q[15:8] ^ pkt_q[7:0];
`endif
            default: cur_byte = '0;
        endcase
    end

    // uart_tx is registered from the current state, so the line trails the FSM by one cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        load    = 1'b0;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (!empty && cts_s) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                tx_d = cur_byte[bit_q];
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = WAIT_CTS;
                    end else begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            WAIT_CTS: begin
                if (cts_s) state_d = START;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            pkt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= (state_q != IDLE) || !empty;
            if (load) pkt_q <= mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_face_result_uart_tx.sv
// Directed bench for face_result_uart_tx: bench-side UART receiver checks packet bytes and cycle timing.
// Honours FACE_TX_CHECKSUM_EN to expect the extra XOR byte.
module tb_face_result_uart_tx;

    localparam int BAUD = 54;
`ifdef FACE_TX_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    localparam int SLOT  = 10 * BAUD + 1;
    localparam int PKT   = NB * SLOT - 1;
    localparam int LIMIT = 20000;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rec_valid = 1'b0;
    logic       rec_ready;
    logic [7:0] rec_found = '0, rec_r0 = '0, rec_c0 = '0, rec_r1 = '0, rec_c1 = '0;
    logic       uart_cts = 1'b1;
    logic       uart_tx, uart_rts, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] rf [5];
    logic [7:0] rr0 [5];
    logic [7:0] rc0 [5];
    logic [7:0] rr1 [5];
    logic [7:0] rc1 [5];

    face_result_uart_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_found (rec_found),
        .rec_r0    (rec_r0),
        .rec_c0    (rec_c0),
        .rec_r1    (rec_r1),
        .rec_c1    (rec_c1),
        .uart_cts  (uart_cts),
        .uart_tx   (uart_tx),
        .uart_rts  (uart_rts),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input int idx);
        case (idx)
            0:       return rf[i];
            1:       return rc0[i];
            2:       return rr0[i];
            3:       return rc1[i];
            4:       return rr1[i];
            default: return rf[i] ^ rc0[i] ^ rr0[i] ^ rc1[i] ^ rr1[i];
        endcase
    endfunction

    task automatic set_rec(input int i);
        rec_found = rf[i];
        rec_r0    = rr0[i];
        rec_c0    = rc0[i];
        rec_r1    = rr1[i];
        rec_c1    = rc1[i];
    endtask

    // k is the cycle on which the start bit is first seen low; bits are sampled mid-period.
    task automatic rx_byte(output logic [7:0] b, output int k, input bit drop);
        int n;
        n = 0;
        b = '0;
        while (uart_tx !== 1'b0 && n < LIMIT) begin
            tick();
            n++;
        end
        k = cyc;
        chk("rx_start_timeout", 32'(n >= LIMIT), 32'd0);
        wait_n(BAUD / 2);
        chk("rx_start_bit", 32'(uart_tx), 32'd0);
        for (int j = 0; j < 8; j++) begin
            wait_n(BAUD);
            b[j] = uart_tx;
            if (drop && j == 2) uart_cts = 1'b0;
        end
        wait_n(BAUD);
        chk("rx_stop_bit", 32'(uart_tx), 32'd1);
    endtask

    task automatic rx_pkt(input int i, output int kfirst);
        logic [7:0] got;
        int k, kprev;
        kprev = 0;
        kfirst = 0;
        for (int b = 0; b < NB; b++) begin
            rx_byte(got, k, 1'b0);
            if (b == 0) kfirst = k;
            else chk("byte_gap", k, kprev + SLOT);
            chk($sformatf("rec%0d_byte%0d", i, b), 32'(got), 32'(exp_byte(i, b)));
            kprev = k;
        end
    endtask

    initial begin
        int c0, cr, k, k1, lows, highs;
        logic [7:0] got;

        rf[0] = 8'h01; rr0[0] = 8'd10;  rc0[0] = 8'd20;  rr1[0] = 8'd34;  rc1[0] = 8'd44;
        rf[1] = 8'h02; rr0[1] = 8'h55;  rc0[1] = 8'hAA;  rr1[1] = 8'hFF;  rc1[1] = 8'h00;
        rf[2] = 8'h80; rr0[2] = 8'h01;  rc0[2] = 8'h7E;  rr1[2] = 8'h81;  rc1[2] = 8'hC3;
        rf[3] = 8'h00; rr0[3] = 8'h12;  rc0[3] = 8'h34;  rr1[3] = 8'h56;  rc1[3] = 8'h78;
        rf[4] = 8'hFF; rr0[4] = 8'h9A;  rc0[4] = 8'hBC;  rr1[4] = 8'hDE;  rc1[4] = 8'hF0;

        // Reset and idle
        wait_n(5);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_rts", 32'(uart_rts), 32'd0);
        chk("rst_ready", 32'(rec_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rel_rts", 32'(uart_rts), 32'd1);
        chk("rel_ready", 32'(rec_ready), 32'd1);
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        chk("idle_tx_lows", lows, 0);

        // Single record, CTS high
        set_rec(0);
        rec_valid = 1'b1;
        tick();
        c0 = cyc;
        rec_valid = 1'b0;
        chk("lat_tx_c1", 32'(uart_tx), 32'd1);
        rx_pkt(0, k);
        chk("lat_start", k, c0 + 2);
        wait_until(c0 + 1 + PKT);
        chk("single_busy_hi", 32'(busy), 32'd1);
        tick();
        chk("single_busy_lo", 32'(busy), 32'd0);
        chk("single_tx_idle", 32'(uart_tx), 32'd1);

        // FIFO full with CTS low, then drain
        uart_cts = 1'b0;
        wait_n(5);
        for (int i = 0; i < 4; i++) begin
            set_rec(i);
            rec_valid = 1'b1;
            chk($sformatf("fill_ready%0d", i), 32'(rec_ready), 32'd1);
            tick();
        end
        set_rec(4);
        chk("full_ready", 32'(rec_ready), 32'd0);
        lows = 0;
        highs = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
            if (rec_ready !== 1'b0) highs++;
        end
        chk("full_tx_lows", lows, 0);
        chk("full_ready_highs", highs, 0);
        chk("full_busy", 32'(busy), 32'd1);
        uart_cts = 1'b1;
        cr = cyc;
        rx_pkt(0, k);
        chk("drain_first_start", k, cr + 4);
        wait_until(cr + 2 + PKT);
        chk("pop_ready_before", 32'(rec_ready), 32'd0);
        tick();
        chk("pop_ready_after", 32'(rec_ready), 32'd1);
        tick();
        rec_valid = 1'b0;
        k1 = k;
        for (int i = 1; i < 5; i++) begin
            rx_pkt(i, k);
            chk($sformatf("pkt%0d_spacing", i), k, k1 + PKT + 1);
            k1 = k;
        end
        wait_until(k1 + PKT);
        chk("drain_busy_lo", 32'(busy), 32'd0);

        // CTS dropped during byte 2 data
        wait_n(10);
        set_rec(1);
        rec_valid = 1'b1;
        tick();
        rec_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rx_byte(got, k, 1'b0);
            chk($sformatf("cts_byte%0d", b), 32'(got), 32'(exp_byte(1, b)));
        end
        rx_byte(got, k, 1'b1);
        chk("cts_byte2", 32'(got), 32'(exp_byte(1, 2)));
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        chk("cts_hold_lows", lows, 0);
        uart_cts = 1'b1;
        cr = cyc;
        wait_n(3);
        chk("cts_resume_c3", 32'(uart_tx), 32'd1);
        tick();
        chk("cts_resume_c4", 32'(uart_tx), 32'd0);
        for (int b = 3; b < NB; b++) begin
            rx_byte(got, k, 1'b0);
            chk($sformatf("cts_byte%0d", b), 32'(got), 32'(exp_byte(1, b)));
        end
        wait_until(k + SLOT);
        chk("cts_busy_lo", 32'(busy), 32'd0);

        // Reset during byte 1 data
        wait_n(10);
        set_rec(2);
        rec_valid = 1'b1;
        tick();
        rec_valid = 1'b0;
        rx_byte(got, k, 1'b0);
        chk("rstmid_byte0", 32'(got), 32'(exp_byte(2, 0)));
        wait_until(k + SLOT + 200);
        chk("rstmid_pre_tx", 32'(uart_tx), 32'(exp_byte(2, 1) >> 2) & 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_tx", 32'(uart_tx), 32'd1);
        chk("rstmid_ready", 32'(rec_ready), 32'd0);
        chk("rstmid_rts", 32'(uart_rts), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        wait_n(3);
        reset_n = 1'b1;
        tick();
        lows = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        chk("rstmid_tx_lows", lows, 0);
        chk("rstmid_busy_after", 32'(busy), 32'd0);
        chk("rstmid_ready_after", 32'(rec_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
